// File: rtl/bf16_add_normalize_if.sv
// Bus bundle between the bf16 add branch and its normalise/round/pack stage.
// The master drives the un-normalised sum; the slave returns the packed bfloat16 result.
interface bf16_add_normalize_if #(
  parameter int unsigned G = 6
);
  logic            in_valid;
  logic [G+15:0]   in_alu_r;
  logic [31:0]     in_exp_r;
  logic            in_s_r;
  logic            in_exc_flag;
  logic            in_err_code;
  logic            out_valid;
  logic [15:0]     out_result;
  logic            out_ovf;
  logic            out_unf;
  logic            out_inexact;

  modport master (
    output in_valid, in_alu_r, in_exp_r, in_s_r, in_exc_flag, in_err_code,
    input  out_valid, out_result, out_ovf, out_unf, out_inexact
  );

  modport slave (
    input  in_valid, in_alu_r, in_exp_r, in_s_r, in_exc_flag, in_err_code,
    output out_valid, out_result, out_ovf, out_unf, out_inexact
  );
endinterface

// File: rtl/bf16_add_normalize.sv
// Normalise, round-to-nearest-even and pack a bf16 adder sum.
// Pipeline: S1 input + leading-one, S2 normalise, S3 round, then packed output registers.
module bf16_add_normalize #(
   parameter int unsigned G = 6
) (
   input  logic                   clk,
   input  logic                   reset,
   bf16_add_normalize_if.slave    bus
);

   localparam int unsigned W  = G + 16;
   localparam int unsigned H  = G + 7;
   localparam int unsigned PW = $clog2(W);

   // S1
   logic          v1_q, s1_q, exc1_q, err1_q, z1_q;
   logic [W-1:0]  alu1_q;
   logic [31:0]   exp1_q;
   logic [PW-1:0] p1_q, p1_d;
   // S2 (hidden bit dropped: always 1 for non-zero sums)
   logic          v2_q, s2_q, exc2_q, err2_q, z2_q, sticky2_q, sticky2_d;
   logic [H-1:0]  mant2_q, mant2_d;
   logic [31:0]   e2_q, e2_d;
   logic [PW-1:0] sh;
   // S3
   logic          v3_q, s3_q, exc3_q, err3_q, z3_q, inx3_q, inx3_d;
   logic [6:0]    frac3_q, frac3_d;
   logic [31:0]   e3_q, e3_d;
   logic          lsb, rnd, stk, inc, carry;
   // Output
   logic          valid_q, ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;
   logic [15:0]   result_q, result_d;

   always_comb begin
      p1_d = '0;
      for (int i = 0; i < int'(W); i++) begin
         if (bus.in_alu_r[i]) p1_d = PW'(i);
      end
   end

   always_comb begin
      sh        = '0;
      mant2_d   = '0;
      sticky2_d = 1'b0;
      if (p1_q > PW'(H)) begin
         sh        = p1_q - PW'(H);
         mant2_d   = H'(alu1_q >> sh);
         sticky2_d = |(alu1_q & ~({W{1'b1}} << sh));
      end else begin
         sh      = PW'(H) - p1_q;
         mant2_d = H'(alu1_q << sh);
      end
      e2_d = exp1_q + 32'(p1_q) - 32'(H);
   end

   always_comb begin
      lsb     = mant2_q[G];
      rnd     = mant2_q[G-1];
      stk     = (|mant2_q[G-2:0]) | sticky2_q;
      inc     = rnd & (stk | lsb);
      // All-ones fraction plus increment wraps to zero and bumps the exponent.
      carry   = inc & (&mant2_q[H-1:G]);
      frac3_d = mant2_q[H-1:G] + 7'(inc);
      e3_d    = e2_q + 32'(carry);
      inx3_d  = rnd | stk;
   end

   always_comb begin
      result_d = {s3_q, e3_q[7:0], frac3_q};
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      inx_d    = inx3_q;
      if (exc3_q) begin
         result_d = err3_q ? 16'h7FC0 : {s3_q, 8'hFF, 7'h0};
         inx_d    = 1'b0;
      end else if (z3_q) begin
         result_d = 16'h0000;
         inx_d    = 1'b0;
      end else if ($signed(e3_q) >= 32'sd255) begin
         result_d = {s3_q, 8'hFF, 7'h0};
         ovf_d    = 1'b1;
         inx_d    = 1'b1;
      end else if ($signed(e3_q) <= 32'sd0) begin
         result_d = {s3_q, 15'h0};
         unf_d    = 1'b1;
         inx_d    = 1'b1;
      end
      if (!v3_q) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
         inx_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1_q      <= 1'b0;  s1_q <= 1'b0;  exc1_q <= 1'b0;  err1_q <= 1'b0;  z1_q <= 1'b0;
         alu1_q    <= '0;    exp1_q <= '0;  p1_q <= '0;
         v2_q      <= 1'b0;  s2_q <= 1'b0;  exc2_q <= 1'b0;  err2_q <= 1'b0;  z2_q <= 1'b0;
         sticky2_q <= 1'b0;  mant2_q <= '0; e2_q <= '0;
         v3_q      <= 1'b0;  s3_q <= 1'b0;  exc3_q <= 1'b0;  err3_q <= 1'b0;  z3_q <= 1'b0;
         inx3_q    <= 1'b0;  frac3_q <= '0; e3_q <= '0;
         valid_q   <= 1'b0;  result_q <= '0; ovf_q <= 1'b0;  unf_q <= 1'b0;   inx_q <= 1'b0;
      end else begin
         v1_q      <= bus.in_valid;
         s1_q      <= bus.in_s_r;
         exc1_q    <= bus.in_exc_flag;
         err1_q    <= bus.in_err_code;
         z1_q      <= (bus.in_alu_r == '0);
         alu1_q    <= bus.in_alu_r;
         exp1_q    <= bus.in_exp_r;
         p1_q      <= p1_d;
         v2_q      <= v1_q;
         s2_q      <= s1_q;
         exc2_q    <= exc1_q;
         err2_q    <= err1_q;
         z2_q      <= z1_q;
         sticky2_q <= sticky2_d;
         mant2_q   <= mant2_d;
         e2_q      <= e2_d;
         v3_q      <= v2_q;
         s3_q      <= s2_q;
         exc3_q    <= exc2_q;
         err3_q    <= err2_q;
         z3_q      <= z2_q;
         inx3_q    <= inx3_d;
         frac3_q   <= frac3_d;
         e3_q      <= e3_d;
         valid_q   <= v3_q;
         result_q  <= result_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         inx_q     <= inx_d;
      end
   end

   assign bus.out_valid   = valid_q;
   assign bus.out_result  = result_q;
   assign bus.out_ovf     = ovf_q;
   assign bus.out_unf     = unf_q;
   assign bus.out_inexact = inx_q;

endmodule

// File: tb/tb_bf16_add_normalize.sv
// Bench for bf16_add_normalize: vector table through a latency-tagged scoreboard,
// plus bubble and mid-stream reset sequences.
module tb_bf16_add_normalize;

   localparam int unsigned G = 6;

   logic clk;
   logic reset;

   bf16_add_normalize_if #(.G(G)) bus ();

   bf16_add_normalize #(.G(G)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [21:0] alu;
      logic [31:0] exp;
      logic        s;
      logic        exc;
      logic        err;
      logic [15:0] res;
      logic        ovf;
      logic        unf;
      logic        inx;
   } vec_t;

   typedef struct {
      logic [15:0] res;
      logic        ovf;
      logic        unf;
      logic        inx;
      int unsigned due;
      int          id;
   } exp_t;

   localparam int NV = 18;
   vec_t        vecs [NV];
   exp_t        sb [$];
   int unsigned cyc;
   int          tests;
   int          fails;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic vec_t mk(logic [21:0] a, logic [31:0] e, logic s, logic exc, logic err,
                               logic [15:0] r, logic ovf, logic unf, logic inx);
      vec_t v;
      v.alu = a; v.exp = e; v.s = s; v.exc = exc; v.err = err;
      v.res = r; v.ovf = ovf; v.unf = unf; v.inx = inx;
      return v;
   endfunction

   function automatic void check(string name, logic [31:0] act, logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endfunction

   // Call right after a posedge; leaves the bench just after the next posedge.
   task automatic drive(vec_t v, int id);
      exp_t e;
      bus.in_valid    = 1'b1;
      bus.in_alu_r    = v.alu;
      bus.in_exp_r    = v.exp;
      bus.in_s_r      = v.s;
      bus.in_exc_flag = v.exc;
      bus.in_err_code = v.err;
      e.res = v.res; e.ovf = v.ovf; e.unf = v.unf; e.inx = v.inx;
      e.due = cyc + 4;
      e.id  = id;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic bubble();
      bus.in_valid = 1'b0;
      bus.in_alu_r = 22'h3FFFFF;
      @(posedge clk);
      #1;
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (bus.out_valid) begin
               if (sb.size() == 0) begin
                  check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
               end else begin
                  e = sb.pop_front();
                  check($sformatf("latency[%0d]", e.id), cyc, e.due);
                  check($sformatf("result[%0d]", e.id), 32'(bus.out_result), 32'(e.res));
                  check($sformatf("flags[%0d]", e.id),
                        {29'd0, bus.out_ovf, bus.out_unf, bus.out_inexact},
                        {29'd0, e.ovf, e.unf, e.inx});
               end
            end else begin
               check("idle_flags", {29'd0, bus.out_ovf, bus.out_unf, bus.out_inexact}, 32'd0);
            end
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      cyc   = 0;
      reset = 1'b0;
      bus.in_valid    = 1'b0;
      bus.in_alu_r    = '0;
      bus.in_exp_r    = '0;
      bus.in_s_r      = 1'b0;
      bus.in_exc_flag = 1'b0;
      bus.in_err_code = 1'b0;

      vecs[0]  = mk(22'h004000, 32'd127, 1'b0, 1'b0, 1'b0, 16'h4000, 1'b0, 1'b0, 1'b0);
      vecs[1]  = mk(22'h002020, 32'd127, 1'b0, 1'b0, 1'b0, 16'h3F80, 1'b0, 1'b0, 1'b1);
      vecs[2]  = mk(22'h002060, 32'd127, 1'b0, 1'b0, 1'b0, 16'h3F82, 1'b0, 1'b0, 1'b1);
      vecs[3]  = mk(22'h003FFF, 32'd127, 1'b0, 1'b0, 1'b0, 16'h4000, 1'b0, 1'b0, 1'b1);
      vecs[4]  = mk(22'h000040, 32'd134, 1'b1, 1'b0, 1'b0, 16'hBF80, 1'b0, 1'b0, 1'b0);
      vecs[5]  = mk(22'h004000, 32'd254, 1'b0, 1'b0, 1'b0, 16'h7F80, 1'b1, 1'b0, 1'b1);
      vecs[6]  = mk(22'h002000, 32'd0,   1'b1, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
      vecs[7]  = mk(22'h000000, 32'd127, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      vecs[8]  = mk(22'h004000, 32'd127, 1'b0, 1'b1, 1'b1, 16'h7FC0, 1'b0, 1'b0, 1'b0);
      vecs[9]  = mk(22'h004000, 32'd127, 1'b1, 1'b1, 1'b0, 16'hFF80, 1'b0, 1'b0, 1'b0);
      vecs[10] = mk(22'h003FFF, 32'd254, 1'b0, 1'b0, 1'b0, 16'h7F80, 1'b1, 1'b0, 1'b1);
      vecs[11] = mk(22'h200001, 32'd100, 1'b0, 1'b0, 1'b0, 16'h3600, 1'b0, 1'b0, 1'b1);
      vecs[12] = mk(22'h000001, 32'd13,  1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
      vecs[13] = mk(22'h002000, 32'h80000005, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
      vecs[14] = mk(22'h002021, 32'd127, 1'b0, 1'b0, 1'b0, 16'h3F81, 1'b0, 1'b0, 1'b1);
      vecs[15] = mk(22'h004041, 32'd127, 1'b0, 1'b0, 1'b0, 16'h4001, 1'b0, 1'b0, 1'b1);
      vecs[16] = mk(22'h002000, 32'd1,   1'b0, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b0, 1'b0);
      vecs[17] = mk(22'h002000, 32'd254, 1'b0, 1'b0, 1'b0, 16'h7F00, 1'b0, 1'b0, 1'b0);

      fork
         monitor();
      join_none

      #12;
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_out_result", 32'(bus.out_result), 32'd0);
      check("reset_flags", {29'd0, bus.out_ovf, bus.out_unf, bus.out_inexact}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Full-throughput table
      for (int i = 0; i < NV; i++) drive(vecs[i], i);
      bubble();
      bubble();

      // Back-to-back with a gap
      drive(vecs[0], 100);
      drive(vecs[5], 101);
      bubble();
      drive(vecs[8], 102);
      drive(vecs[9], 103);
      for (int i = 0; i < 6; i++) bubble();
      check("drain_before_reset", sb.size(), 32'd0);

      // Reset with three ops in flight, one already presented
      drive(vecs[0], 200);
      drive(vecs[3], 201);
      drive(vecs[4], 202);
      bubble();
      @(negedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      #1;
      check("async_reset_valid", 32'(bus.out_valid), 32'd0);
      check("async_reset_result", 32'(bus.out_result), 32'd0);
      check("async_reset_flags", {29'd0, bus.out_ovf, bus.out_unf, bus.out_inexact}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) bubble();
      drive(vecs[2], 300);

      for (int i = 0; i < 20 && sb.size() != 0; i++) bubble();
      check("scoreboard_drain", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
